// File: rtl/crc10_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : crc10_frame_gen
// Description : CRC10 framer for a 62-bit payload stream. A frame is 26
//               accepted beats. The beat is split into four groups:
//                 g1 = [61:47] (15b)   g2 = [46:32] (15b)
//                 g3 = [31:16] (16b)   g4 = [15:0]  (16b)
//               Each group feeds its own CRC10 block:
//                 block1 = g1 over beats 0..25         (390b)
//                 block2 = g2 over beats 0..24 + 3b    (378b)
//                 block3 = g3 over beats 0..24         (400b)
//                 block4 = g4 over beats 0..24         (400b)
//               Beats 0..24 pass through unchanged. Beat 25 carries g1, the
//               last 3 bits of block2, the four CRCs and the TAIL bits.
//               The CRC is MSB first, init 0, no reflection, no final XOR.
//
// Parameters  : POLY  - CRC10 generator polynomial, x^10 term implicit
//               TAIL  - 4 bits placed in the LSBs of the tail beat
//
// Ports       : clk_390p625M     in   1   clock, rising edge
//               rst              in   1   asynchronous active-high reset
//               in_sof           in   1   start of frame, qualified by in_valid
//               in_valid         in   1   payload beat valid
//               in_data          in  62   payload beat
//               err_inject       in   1   (CRC10_ERR_INJECT_EN only) flips
//                                         crc4 bit 0 on the tail beat output
//               crc10_en         out  1   output beat valid
//               crc10_data_out   out 62   framed beat
//               frame_tail_flag  out  1   marks the tail beat
//               frame_cnt        out 23   completed frames, saturating
//
// Build macro : CRC10_ERR_INJECT_EN adds the err_inject port.
//
// Revision    : 1.0 - initial release
// ============================================================================
module crc10_frame_gen #(
  parameter logic [9:0] POLY = 10'b1000110011,
  parameter logic [3:0] TAIL = 4'b0000
) (
  input  logic        clk_390p625M,
  input  logic        rst,
  input  logic        in_sof,
  input  logic        in_valid,
  input  logic [61:0] in_data,
`ifdef CRC10_ERR_INJECT_EN
  input  logic        err_inject,
`endif
  output logic        crc10_en,
  output logic [61:0] crc10_data_out,
  output logic        frame_tail_flag,
  output logic [22:0] frame_cnt
);

  localparam logic [4:0]  c_last_beat = 5'd25;
  localparam logic [22:0] c_cnt_max   = 23'h7FFFFF;

  // Serial CRC update over the low nbits of data, MSB first.
  function automatic logic [9:0] crc_upd(input logic [9:0] crc,
                                         input logic [15:0] data,
                                         input int nbits);
    logic [9:0] c;
    logic       fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (i < nbits) begin
        fb = c[9] ^ data[i];
        c  = {c[8:0], 1'b0} ^ (fb ? POLY : 10'd0);
      end
    end
    return c;
  endfunction

  logic [4:0]  cnt_q, cnt_d;
  logic [9:0]  crc1_q, crc1_d;
  logic [9:0]  crc2_q, crc2_d;
  logic [9:0]  crc3_q, crc3_d;
  logic [9:0]  crc4_q, crc4_d;
  logic        en_q, en_d;
  logic        tail_q, tail_d;
  logic [61:0] data_q, data_d;
  logic [22:0] frame_cnt_q, frame_cnt_d;

  logic [4:0]  w_beat;
  logic        w_is_tail;
  logic [9:0]  w_base1, w_base2, w_base3, w_base4;
  logic [9:0]  w_crc1_nxt, w_crc2_nxt, w_crc3_nxt, w_crc4_nxt;
  logic [9:0]  w_inj;

`ifdef CRC10_ERR_INJECT_EN
  assign w_inj = {9'd0, err_inject};
`else
  assign w_inj = 10'd0;
`endif

  // A start-of-frame beat is beat 0 with fresh CRCs, whatever the counter
  // says; this is also what aborts a partial frame.
  assign w_beat    = in_sof ? 5'd0 : cnt_q;
  assign w_is_tail = (w_beat == c_last_beat);
  assign w_base1   = in_sof ? 10'd0 : crc1_q;
  assign w_base2   = in_sof ? 10'd0 : crc2_q;
  assign w_base3   = in_sof ? 10'd0 : crc3_q;
  assign w_base4   = in_sof ? 10'd0 : crc4_q;

  // Block2 takes only 3 bits (in_data[46:44]) on the tail beat.
  assign w_crc1_nxt = crc_upd(w_base1, {1'b0, in_data[61:47]}, 15);
  assign w_crc2_nxt = w_is_tail ? crc_upd(w_base2, {13'd0, in_data[46:44]}, 3)
                                : crc_upd(w_base2, {1'b0, in_data[46:32]}, 15);
  assign w_crc3_nxt = crc_upd(w_base3, in_data[31:16], 16);
  assign w_crc4_nxt = crc_upd(w_base4, in_data[15:0], 16);

  always_comb begin
    cnt_d       = cnt_q;
    crc1_d      = crc1_q;
    crc2_d      = crc2_q;
    crc3_d      = crc3_q;
    crc4_d      = crc4_q;
    en_d        = in_valid;
    tail_d      = 1'b0;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    if (in_valid) begin
      if (w_is_tail) begin
        // Tail layout flattens to {g1, g2[14:12], crc1, crc2, crc3, crc4, TAIL}.
        // crc3/crc4 are already complete (blocks 3 and 4 end at beat 24).
        data_d      = {in_data[61:44], w_crc1_nxt, w_crc2_nxt,
                       crc3_q, crc4_q ^ w_inj, TAIL};
        tail_d      = 1'b1;
        cnt_d       = 5'd0;
        crc1_d      = 10'd0;
        crc2_d      = 10'd0;
        crc3_d      = 10'd0;
        crc4_d      = 10'd0;
        frame_cnt_d = (frame_cnt_q == c_cnt_max) ? frame_cnt_q
                                                 : frame_cnt_q + 23'd1;
      end else begin
        data_d = in_data;
        cnt_d  = w_beat + 5'd1;
        crc1_d = w_crc1_nxt;
        crc2_d = w_crc2_nxt;
        crc3_d = w_crc3_nxt;
        crc4_d = w_crc4_nxt;
      end
    end
  end

  always_ff @(posedge clk_390p625M or posedge rst) begin
    if (rst) begin
      cnt_q       <= 5'd0;
      crc1_q      <= 10'd0;
      crc2_q      <= 10'd0;
      crc3_q      <= 10'd0;
      crc4_q      <= 10'd0;
      en_q        <= 1'b0;
      tail_q      <= 1'b0;
      data_q      <= 62'd0;
      frame_cnt_q <= 23'd0;
    end else begin
      cnt_q       <= cnt_d;
      crc1_q      <= crc1_d;
      crc2_q      <= crc2_d;
      crc3_q      <= crc3_d;
      crc4_q      <= crc4_d;
      en_q        <= en_d;
      tail_q      <= tail_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign crc10_en        = en_q;
  assign crc10_data_out  = data_q;
  assign frame_tail_flag = tail_q;
  assign frame_cnt       = frame_cnt_q;

endmodule
`default_nettype wire
